demux_32_reg: RTL and testbench
===============================

# demux_32_reg

Registered 1-to-32 demultiplexer: the write-side counterpart of `mux_32`. On each enabled clock edge it steers a 32-bit input word into one of 32 holding registers chosen by a 5-bit select. All 32 registers are driven continuously on parallel outputs, so a `mux_32` can read any of them back. It forms the write half of the register-file datapath, and also produces per-channel write strobes and a saturating write counter for debug and verification.

## Interface
- `WIDTH`, default 32: data width of every channel.
- `CNT_W`, default 8: width of the write counter.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `we`  in  1: write enable, sampled on the rising edge of `clock`.
- `clear`  in  1: synchronous clear of all holding registers.
- `select`  in  5: destination channel index, 0..31.
- `data_in`  in  WIDTH: word to be written.
- `out0` … `out31`  out  WIDTH each: holding register contents, one port per channel.
- `strobe`  out  32: one-hot registered write pulse; bit N is high for one cycle after channel N is written.
- `write_count`  out  CNT_W: number of accepted writes, saturating.

## Operation
- **Write:**
  - On a rising edge with `we`=1 and `clear`=0, register `select` loads `data_in`.
  - All other registers hold their values.
  - `strobe` becomes one-hot at bit `select`.
  - `write_count` increments by 1 and saturates at 2^CNT_W−1; it never wraps.
- **Idle:** on a rising edge with `we`=0 and `clear`=0, all registers hold, `strobe` becomes all-zero and `write_count` holds.
- **Clear:**
  - On a rising edge with `clear`=1, all 32 registers go to 0 and `strobe` goes to 0.
  - `write_count` is not cleared.
  - `clear` has priority over `we`: a write in the same cycle is discarded and not counted.
- **Select decoding:** `select` is decoded by a 5-to-32 one-hot decoder gated by `we & ~clear`. Exactly one channel, or none, is written per cycle.
- **Back-to-back writes:**
  - Consecutive writes to the same channel: the last write wins, `strobe` bit N stays high for every such cycle, and each write is counted.
  - Consecutive writes to different channels: `strobe` moves to the new bit; it is never multi-hot.
- **Unknown select:** an X or Z on `select` while `we`=1 is a bench error. The RTL does not need to defend against it.

## Timing
- **Reset values:** `out0`…`out31` = 0, `strobe` = 0, `write_count` = 0. These values apply asynchronously as soon as `reset` rises.
- **Reset mid-operation:** `reset` overrides `we` and `clear` on any cycle. The first write is accepted on the first rising edge after `reset` deasserts.
- **Write latency:** 1 cycle. New data is visible on `outN` immediately after the capturing edge, and `strobe[N]` is high for that same following cycle.
- **Read path:** `outN` is a direct register output with no combinational path from any input, so a downstream `mux_32` sees a stable value for the whole cycle.
- **Counter:** `write_count` is registered and updates on the same edge as the data.

## Configuration
- The macro `DEMUX_32_ZERO_REG_EN` controls channel 0.
- **When defined:** channel 0 is hardwired.
  - `out0` is constant 0 and has no storage.
  - A write with `select`=0 is dropped: no strobe bit, no count increment.
- **When undefined:** channel 0 is an ordinary register, identical in behaviour to channels 1–31.

## Structure
- **Package `demux_32_pkg`:** holds the constants `NUM_CH`=32, `SEL_W`=5, `DATA_W`=32 and `CNT_W`=8. `mux_32` and the register file share these.
- **Sub-module `decoder_5_32`:** a combinational 5-to-32 one-hot decoder with enable. It is instantiated once and drives the per-channel load enables; the registered `strobe` is that decoder output captured on the clock edge.
- **Top level:** contains the 32 holding registers, created with a generate loop, plus the counter and strobe registers.

## Test plan
1. **Reset:** assert `reset` for 2 cycles -> all `outN`=0, `strobe`=0, `write_count`=0. Also assert `reset` mid-cycle -> outputs clear without waiting for an edge.
2. **Sweep writes:** write `data_in`=i with `select`=i for i=0..31 -> after each edge, `outi`=i, `strobe`=1<<i, other channels unchanged; final `write_count`=32 (31 with `DEMUX_32_ZERO_REG_EN`, where `out0` stays 0).
3. **Overwrite:** write 0xDEADBEEF then 0x12345678 to channel 7 on consecutive edges -> `out7`=0x12345678, `strobe[7]` high for both cycles, `write_count` +2.
4. **Clear vs write:** `clear`=1 and `we`=1, `select`=3, `data_in`=0xFF on the same edge -> all `outN`=0, `strobe`=0, `write_count` unchanged.
5. **Counter saturation:** 300 consecutive writes -> `write_count` stops at 255. A following idle cycle -> `strobe`=0.
6. **Loopback:** connect the outputs to `mux_32` and sweep `select` 0..31 after the sweep in scenario 2 -> `mux_32` output equals the select value for every index.

Source files
------------

// File: rtl/demux_32_pkg.sv
// Shared constants for the demux_32_reg / mux_32 register-file datapath.
package demux_32_pkg;
    localparam int NUM_CH = 32;
    localparam int SEL_W  = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
endpackage

// File: rtl/decoder_5_32.sv
// Combinational 5-to-32 one-hot decoder with enable; all-zero when disabled.
module decoder_5_32
    import demux_32_pkg::*;
(
    input  logic              en,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] onehot
);

    // Single asserted bit at sel while enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_32_reg.sv
// Registered 1-to-32 demultiplexer: write half of the register file.
// Each enabled edge loads data_in into the channel chosen by select; all
// channels are visible on out0..out31. Also produces a registered one-hot
// write strobe and a saturating write counter.
// Optional build macro DEMUX_32_ZERO_REG_EN: channel 0 becomes a constant
// zero with no storage, and writes to it are dropped (no strobe, no count).
module demux_32_reg
    import demux_32_pkg::NUM_CH;
    import demux_32_pkg::SEL_W;
#(
    parameter int WIDTH = demux_32_pkg::DATA_W,
    parameter int CNT_W = demux_32_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              clear,
    input  logic [SEL_W-1:0]  select,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [WIDTH-1:0]  out5,
    output logic [WIDTH-1:0]  out6,
    output logic [WIDTH-1:0]  out7,
    output logic [WIDTH-1:0]  out8,
    output logic [WIDTH-1:0]  out9,
    output logic [WIDTH-1:0]  out10,
    output logic [WIDTH-1:0]  out11,
    output logic [WIDTH-1:0]  out12,
    output logic [WIDTH-1:0]  out13,
    output logic [WIDTH-1:0]  out14,
    output logic [WIDTH-1:0]  out15,
    output logic [WIDTH-1:0]  out16,
    output logic [WIDTH-1:0]  out17,
    output logic [WIDTH-1:0]  out18,
    output logic [WIDTH-1:0]  out19,
    output logic [WIDTH-1:0]  out20,
    output logic [WIDTH-1:0]  out21,
    output logic [WIDTH-1:0]  out22,
    output logic [WIDTH-1:0]  out23,
    output logic [WIDTH-1:0]  out24,
    output logic [WIDTH-1:0]  out25,
    output logic [WIDTH-1:0]  out26,
    output logic [WIDTH-1:0]  out27,
    output logic [WIDTH-1:0]  out28,
    output logic [WIDTH-1:0]  out29,
    output logic [WIDTH-1:0]  out30,
    output logic [WIDTH-1:0]  out31,
    output logic [NUM_CH-1:0] strobe,
    output logic [CNT_W-1:0]  write_count
);

    logic [NUM_CH-1:0] dec;
    logic [NUM_CH-1:0] load;
    logic [WIDTH-1:0]  regs [NUM_CH];

    // Clear dominates: gating the decoder with ~clear means a colliding
    // write produces no load, no strobe and no count.
    decoder_5_32 u_dec (
        .en     (we & ~clear),
        .sel    (select),
        .onehot (dec)
    );

`ifdef DEMUX_32_ZERO_REG_EN
    assign load = {dec[NUM_CH-1:1], 1'b0};
    localparam int FIRST_CH = 1;
`else
    assign load = dec;
    localparam int FIRST_CH = 0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        if (ch < FIRST_CH) begin : g_zero
            assign regs[ch] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] q;
            // Holding register: clear wins, otherwise load on its decoder bit
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else if (clear) begin
                    q <= '0;
                end else if (load[ch]) begin
                    q <= data_in;
                end
            end
            assign regs[ch] = q;
        end
    end

    // Strobe is the gated decoder output delayed one edge (zero on clear/idle)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe <= '0;
        end else begin
            strobe <= load;
        end
    end

    // Count accepted writes, holding at all-ones instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_count <= '0;
        end else if ((|load) && (write_count != {CNT_W{1'b1}})) begin
            write_count <= write_count + CNT_W'(1);
        end
    end

    assign out0  = regs[0];
    assign out1  = regs[1];
    assign out2  = regs[2];
    assign out3  = regs[3];
    assign out4  = regs[4];
    assign out5  = regs[5];
    assign out6  = regs[6];
    assign out7  = regs[7];
    assign out8  = regs[8];
    assign out9  = regs[9];
    assign out10 = regs[10];
    assign out11 = regs[11];
    assign out12 = regs[12];
    assign out13 = regs[13];
    assign out14 = regs[14];
    assign out15 = regs[15];
    assign out16 = regs[16];
    assign out17 = regs[17];
    assign out18 = regs[18];
    assign out19 = regs[19];
    assign out20 = regs[20];
    assign out21 = regs[21];
    assign out22 = regs[22];
    assign out23 = regs[23];
    assign out24 = regs[24];
    assign out25 = regs[25];
    assign out26 = regs[26];
    assign out27 = regs[27];
    assign out28 = regs[28];
    assign out29 = regs[29];
    assign out30 = regs[30];
    assign out31 = regs[31];

endmodule

// File: tb/tb_demux_32_reg.sv
// Self-checking bench for demux_32_reg: directed steps, scoreboard queue of
// expected outputs, bench-side read mux for the loopback sweep.
module tb_demux_32_reg;
    import demux_32_pkg::*;

    localparam int W  = 32;
    localparam int VW = NUM_CH * W;
`ifdef DEMUX_32_ZERO_REG_EN
    localparam bit ZERO_CH = 1'b1;
`else
    localparam bit ZERO_CH = 1'b0;
`endif

    typedef struct packed {
        logic [VW-1:0]     regs;
        logic [NUM_CH-1:0] strb;
        logic [7:0]        cnt;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              we = 1'b0;
    logic              clear = 1'b0;
    logic [4:0]        select = '0;
    logic [W-1:0]      data_in = '0;
    logic [W-1:0]      o [NUM_CH];
    logic [NUM_CH-1:0] strobe;
    logic [7:0]        write_count;

    logic [VW-1:0]     m_regs = '0;
    logic [NUM_CH-1:0] m_strobe = '0;
    logic [7:0]        m_cnt = '0;
    exp_t              sb [$];
    int                total = 0;
    int                bad = 0;

    always #5 clock = ~clock;

    demux_32_reg dut (
        .clock(clock), .reset(reset), .we(we), .clear(clear),
        .select(select), .data_in(data_in),
        .out0(o[0]),   .out1(o[1]),   .out2(o[2]),   .out3(o[3]),
        .out4(o[4]),   .out5(o[5]),   .out6(o[6]),   .out7(o[7]),
        .out8(o[8]),   .out9(o[9]),   .out10(o[10]), .out11(o[11]),
        .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
        .out16(o[16]), .out17(o[17]), .out18(o[18]), .out19(o[19]),
        .out20(o[20]), .out21(o[21]), .out22(o[22]), .out23(o[23]),
        .out24(o[24]), .out25(o[25]), .out26(o[26]), .out27(o[27]),
        .out28(o[28]), .out29(o[29]), .out30(o[30]), .out31(o[31]),
        .strobe(strobe), .write_count(write_count)
    );

    function automatic logic [VW-1:0] pack_outs();
        logic [VW-1:0] p;
        for (int i = 0; i < NUM_CH; i++) p[i*W +: W] = o[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_regs = '0;
        m_strobe = '0;
        m_cnt = '0;
    endtask

    // Drive one edge worth of inputs, predict, then compare after the edge
    task automatic cycle(input logic w, input logic c, input logic [4:0] s,
                         input logic [W-1:0] d, input string tag);
        exp_t e;
        we = w; clear = c; select = s; data_in = d;
        if (c) begin
            m_regs = '0;
            m_strobe = '0;
        end else if (w && !(ZERO_CH && s == 5'd0)) begin
            m_regs[s*W +: W] = d;
            m_strobe = '0;
            m_strobe[s] = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else begin
            m_strobe = '0;
        end
        e.regs = m_regs;
        e.strb = m_strobe;
        e.cnt  = m_cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({tag, "_regs"},   pack_outs(),        e.regs);
        check({tag, "_strobe"}, VW'(strobe),        VW'(e.strb));
        check({tag, "_count"},  VW'(write_count),   VW'(e.cnt));
        we = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges
        repeat (2) @(posedge clock);
        #1;
        check("reset_regs",   pack_outs(),      '0);
        check("reset_strobe", VW'(strobe),      '0);
        check("reset_count",  VW'(write_count), '0);
        reset = 1'b0;
        model_reset();

        // First edge after reset release accepts a write
        cycle(1'b1, 1'b0, 5'd5, 32'h0000_00A5, "post_reset");

        // Asynchronous reset mid-cycle clears without an edge
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_regs",   pack_outs(),      '0);
        check("async_reset_strobe", VW'(strobe),      '0);
        check("async_reset_count",  VW'(write_count), '0);
        model_reset();
        #2;
        reset = 1'b0;

        // Sweep: channel i gets value i
        for (int i = 0; i < NUM_CH; i++) cycle(1'b1, 1'b0, 5'(i), W'(i), "sweep");
        check("sweep_final_count", VW'(write_count), ZERO_CH ? VW'(31) : VW'(32));

        // Loopback through a read mux
        for (int s = 0; s < NUM_CH; s++) begin
            logic [W-1:0] mux_out;
            mux_out = o[s];
            check("loopback", VW'(mux_out), VW'(s));
        end

        // Overwrite the same channel on consecutive edges
        cycle(1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF, "overwrite1");
        cycle(1'b1, 1'b0, 5'd7, 32'h1234_5678, "overwrite2");
        check("overwrite_out7", VW'(o[7]), VW'(32'h1234_5678));

        // Idle edge, then write to a different channel and move strobe
        cycle(1'b0, 1'b0, 5'd9, 32'h5555_5555, "idle");
        cycle(1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, "top_ch");
        cycle(1'b1, 1'b0, 5'd0, 32'hCAFE_0000, "ch0_write");

        // Clear collides with a write; clear wins, nothing counted
        cycle(1'b1, 1'b1, 5'd3, 32'h0000_00FF, "clear_we");

        // Saturation
        for (int k = 0; k < 300; k++)
            cycle(1'b1, 1'b0, 5'($urandom_range(1, 31)), W'($urandom), "saturate");
        check("saturate_count", VW'(write_count), VW'(8'hFF));
        cycle(1'b0, 1'b0, 5'd4, 32'h0, "sat_idle");
        check("sat_idle_strobe", VW'(strobe), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
